// File: rtl/a5_core_pkg.sv
// Shared core constants: sequencer state encoding, halt/memory-class opcode
// markers and the instruction word field layout {opcode[19:12], addr[11:0]}.
package a5_core_pkg;
    localparam int INSTR_W = 20;
    localparam int OP_HI   = 19;
    localparam int OP_LO   = 12;
    localparam int ADDR_HI = 11;
    localparam int ADDR_LO = 0;

    localparam logic [7:0] HALT_OP_DEF = 8'hFF;
    localparam int         MEM_BIT_DEF = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ADDR   = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;
endpackage

// File: rtl/a6_demux_sequencer.sv
// Fetch/decode sequencer feeding the registered data/ALU demux: fetches a word,
// optionally presents the address phase, then runs the ALU via go/done.
module a6_demux_sequencer
    import a5_core_pkg::*;
#(
    parameter int              ADDR_W      = 12,
    parameter int              OP_W        = 8,
    parameter logic [ADDR_W-1:0] PC_RESET  = '0,
    parameter logic [OP_W-1:0] HALT_OP     = HALT_OP_DEF,
    parameter int              MEM_BIT     = MEM_BIT_DEF,
    parameter int              ALU_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_req,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    output logic               select_demux,
    output logic [ADDR_W-1:0]  data_addr,
    output logic [OP_W-1:0]    opcode2,
    output logic               alu_go,
    input  logic               alu_done,
    output logic               busy,
    output logic               halted,
    output logic               err
);
    localparam int               CNT_W   = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ALU_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             halt_pend;
    logic             pc_inc;
    logic             set_err;

    // alu_go is high exactly on the first EXEC cycle, so it also masks the
    // alu_done that may coincide with the go pulse.
    always_comb begin
        state_d = state_q;
        pc_inc  = 1'b0;
        set_err = 1'b0;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (imem_valid) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode2 == HALT_OP)    state_d = S_HALT;
                else if (opcode2[MEM_BIT]) state_d = S_ADDR;
                else                       state_d = S_EXEC;
            end
            S_ADDR:   state_d = S_EXEC;
            S_EXEC: begin
                if (alu_done && !alu_go) begin
                    pc_inc  = 1'b1;
                    state_d = (halt_pend || halt_req) ? S_HALT : S_FETCH;
                end else if (wait_cnt == TO_LAST) begin
                    set_err = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_HALT:   if (start) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_out       <= PC_RESET;
            data_addr    <= '0;
            opcode2      <= '0;
            select_demux <= 1'b1;
            imem_rd      <= 1'b0;
            alu_go       <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            err          <= 1'b0;
            wait_cnt     <= '0;
            halt_pend    <= 1'b0;
        end else begin
            state_q      <= state_d;
            imem_rd      <= (state_d == S_FETCH);
            select_demux <= (state_d != S_EXEC);
            alu_go       <= (state_d == S_EXEC) && (state_q != S_EXEC);
            busy         <= !((state_d == S_IDLE) || (state_d == S_HALT));
            halted       <= (state_d == S_HALT);
            if (set_err) err <= 1'b1;
            if (pc_inc) pc_out <= pc_out + 1'b1;
            if (state_q == S_FETCH && imem_valid) begin
                opcode2   <= imem_data[OP_HI:OP_LO];
                data_addr <= imem_data[ADDR_HI:ADDR_LO];
            end
            wait_cnt <= (state_q == S_EXEC) ? wait_cnt + 1'b1 : '0;
            // halt request is remembered for the whole instruction, forgotten at rest
            if (state_q == S_IDLE || state_q == S_HALT) halt_pend <= 1'b0;
            else if (halt_req)                          halt_pend <= 1'b1;
        end
    end
endmodule
